// File: rtl/seg_scan_arbiter.sv
// rtl/seg_scan_arbiter.sv - two-requester arbiter for an 8-digit multiplexed 7-segment display
// Ownership only changes at frame boundaries so each owner's frame is shown intact.
module seg_scan_arbiter #(
  parameter int SCAN_DIV    = 100000,
  parameter int HOLD_FRAMES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic [31:0] data_a,
  input  logic [31:0] data_b,
  output logic [1:0]  gnt,
  output logic [7:0]  AN,
  output logic [6:0]  seg,
  output logic        frame_done
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q;
  logic [2:0]    digit_q;
  logic [HW-1:0] hold_q;
  logic          last_b_q;
  logic [31:0]   buf_q;
  logic [1:0]    gnt_q;
  logic [7:0]    an_q;
  logic [6:0]    seg_q;
  logic          frame_done_q;
  logic          tick, boundary;
  logic [3:0]    nib;

  assign tick     = (div_q == DW'(SCAN_DIV - 1));
  assign boundary = tick && (digit_q == 3'd7);
  assign nib      = buf_q[{digit_q, 2'b00} +: 4];

  function automatic logic [6:0] dec(input logic [3:0] n);
    case (n)
      4'h0: dec = 7'h40;  4'h1: dec = 7'h79;  4'h2: dec = 7'h24;  4'h3: dec = 7'h30;
      4'h4: dec = 7'h19;  4'h5: dec = 7'h12;  4'h6: dec = 7'h02;  4'h7: dec = 7'h78;
      4'h8: dec = 7'h00;  4'h9: dec = 7'h10;  4'hA: dec = 7'h08;  4'hB: dec = 7'h03;
      4'hC: dec = 7'h46;  4'hD: dec = 7'h21;  4'hE: dec = 7'h06;  default: dec = 7'h7F;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    if (boundary) begin
      case (state_q)
        IDLE: begin
          if (req == 2'b11)   state_d = last_b_q ? OWN_A : OWN_B;
          else if (req[0])    state_d = OWN_A;
          else if (req[1])    state_d = OWN_B;
        end
        OWN_A: begin
          if (!req[0])                     state_d = req[1] ? OWN_B : IDLE;
          else if (hold_q == '0 && req[1]) state_d = OWN_B;
        end
        OWN_B: begin
          if (!req[1])                     state_d = req[0] ? OWN_A : IDLE;
          else if (hold_q == '0 && req[0]) state_d = OWN_A;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q        <= '0;
      digit_q      <= '0;
      state_q      <= IDLE;
      last_b_q     <= 1'b1;
      hold_q       <= '0;
      buf_q        <= '1;
      gnt_q        <= 2'b00;
      an_q         <= 8'hFF;
      seg_q        <= 7'h7F;
      frame_done_q <= 1'b0;
    end else begin
      div_q        <= tick ? '0 : div_q + 1'b1;
      if (tick) digit_q <= digit_q + 3'd1;
      frame_done_q <= boundary;
      state_q      <= state_d;
      gnt_q        <= {state_d == OWN_B, state_d == OWN_A};
      if (boundary) begin
        if (state_d != state_q && state_d != IDLE) begin
          last_b_q <= (state_d == OWN_B);
          hold_q   <= HW'(HOLD_FRAMES - 1);
        end else if (hold_q != '0) begin
          hold_q <= hold_q - 1'b1;
        end
        case (state_d)
          OWN_A:   buf_q <= data_a;
          OWN_B:   buf_q <= data_b;
          default: buf_q <= '1;
        endcase
      end
      // Blank on the next state so the first IDLE cycle is already dark.
      if (state_d == IDLE) begin
        an_q  <= 8'hFF;
        seg_q <= 7'h7F;
      end else begin
        an_q  <= ~(8'd1 << digit_q);
        seg_q <= dec(nib);
      end
    end
  end

  assign gnt        = gnt_q;
  assign AN         = an_q;
  assign seg        = seg_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_arbiter.sv
// tb/tb_seg_scan_arbiter.sv - directed table-driven bench for seg_scan_arbiter
module tb_seg_scan_arbiter;

  logic        clk, rst_n;
  logic [1:0]  req;
  logic [31:0] data_a, data_b;
  logic [1:0]  gnt;
  logic [7:0]  AN;
  logic [6:0]  seg;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int n = 0;

  seg_scan_arbiter #(.SCAN_DIV(4), .HOLD_FRAMES(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data_a(data_a), .data_b(data_b),
    .gnt(gnt), .AN(AN), .seg(seg), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic [1:0]  req;
    logic [31:0] da;
    logic [31:0] db;
    logic [1:0]  gnt;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        fd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int cyc, logic [1:0] r, logic [31:0] a, logic [31:0] b,
                              logic [1:0] g, logic [7:0] an, logic [6:0] s, logic fd);
    vec_t v;
    v.n = cyc; v.req = r; v.da = a; v.db = b; v.gnt = g; v.an = an; v.seg = s; v.fd = fd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s n=%0d actual=%h expected=%h", name, n, act, exp);
    end
  endtask

  // n counts rising edges since the last reset release; checks sit on the falling edge.
  task automatic step_to(input int target);
    while (n < target) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    rst_n = 1'b0; req = 2'b00; data_a = 32'h0; data_b = 32'h0;

    tbl.push_back(mk(  5, 2'b00, 32'h0,        32'h0,        2'b00, 8'hFF, 7'h7F, 1'b0));
    tbl.push_back(mk( 32, 2'b00, 32'h0,        32'h0,        2'b00, 8'hFF, 7'h7F, 1'b1));
    tbl.push_back(mk( 33, 2'b00, 32'h0,        32'h0,        2'b00, 8'hFF, 7'h7F, 1'b0));
    tbl.push_back(mk( 40, 2'b01, 32'h0,        32'h0,        2'b00, 8'hFF, 7'h7F, 1'b0));
    tbl.push_back(mk( 50, 2'b00, 32'h0,        32'h0,        2'b00, 8'hFF, 7'h7F, 1'b0));
    tbl.push_back(mk( 64, 2'b00, 32'h0,        32'h0,        2'b00, 8'hFF, 7'h7F, 1'b1));
    tbl.push_back(mk( 95, 2'b01, 32'h76543210, 32'h0,        2'b00, 8'hFF, 7'h7F, 1'b0));
    tbl.push_back(mk( 96, 2'b01, 32'h76543210, 32'h0,        2'b01, 8'h7F, 7'h7F, 1'b1));
    tbl.push_back(mk( 97, 2'b01, 32'h76543210, 32'h0,        2'b01, 8'hFE, 7'h40, 1'b0));
    tbl.push_back(mk(100, 2'b01, 32'h76543210, 32'h0,        2'b01, 8'hFE, 7'h40, 1'b0));
    tbl.push_back(mk(101, 2'b01, 32'h76543210, 32'h0,        2'b01, 8'hFD, 7'h79, 1'b0));
    tbl.push_back(mk(105, 2'b01, 32'h76543210, 32'h0,        2'b01, 8'hFB, 7'h24, 1'b0));
    tbl.push_back(mk(109, 2'b01, 32'h76543210, 32'h0,        2'b01, 8'hF7, 7'h30, 1'b0));
    tbl.push_back(mk(113, 2'b01, 32'h76543210, 32'h0,        2'b01, 8'hEF, 7'h19, 1'b0));
    tbl.push_back(mk(117, 2'b01, 32'h76543210, 32'h0,        2'b01, 8'hDF, 7'h12, 1'b0));
    tbl.push_back(mk(121, 2'b01, 32'h76543210, 32'h0,        2'b01, 8'hBF, 7'h02, 1'b0));
    tbl.push_back(mk(125, 2'b01, 32'h76543210, 32'h0,        2'b01, 8'h7F, 7'h78, 1'b0));
    tbl.push_back(mk(128, 2'b01, 32'h76543210, 32'h0,        2'b01, 8'h7F, 7'h78, 1'b1));
    tbl.push_back(mk(130, 2'b10, 32'h0,        32'h89ABCDEF, 2'b01, 8'hFE, 7'h40, 1'b0));
    tbl.push_back(mk(135, 2'b10, 32'h0,        32'h89ABCDEF, 2'b01, 8'hFD, 7'h79, 1'b0));
    tbl.push_back(mk(160, 2'b10, 32'h0,        32'h89ABCDEF, 2'b10, 8'h7F, 7'h78, 1'b1));
    tbl.push_back(mk(161, 2'b10, 32'h0,        32'h89ABCDEF, 2'b10, 8'hFE, 7'h7F, 1'b0));
    tbl.push_back(mk(165, 2'b10, 32'h0,        32'h89ABCDEF, 2'b10, 8'hFD, 7'h06, 1'b0));
    tbl.push_back(mk(169, 2'b10, 32'h0,        32'h89ABCDEF, 2'b10, 8'hFB, 7'h21, 1'b0));
    tbl.push_back(mk(173, 2'b10, 32'h0,        32'h89ABCDEF, 2'b10, 8'hF7, 7'h46, 1'b0));
    tbl.push_back(mk(177, 2'b10, 32'h0,        32'h89ABCDEF, 2'b10, 8'hEF, 7'h03, 1'b0));
    tbl.push_back(mk(181, 2'b10, 32'h0,        32'h89ABCDEF, 2'b10, 8'hDF, 7'h08, 1'b0));
    tbl.push_back(mk(185, 2'b10, 32'h0,        32'h89ABCDEF, 2'b10, 8'hBF, 7'h10, 1'b0));
    tbl.push_back(mk(189, 2'b10, 32'h0,        32'h89ABCDEF, 2'b10, 8'h7F, 7'h00, 1'b0));
    tbl.push_back(mk(190, 2'b10, 32'h0,        32'hFFFFFFFF, 2'b10, 8'h7F, 7'h00, 1'b0));
    tbl.push_back(mk(193, 2'b10, 32'h0,        32'hFFFFFFFF, 2'b10, 8'hFE, 7'h7F, 1'b0));
    tbl.push_back(mk(197, 2'b10, 32'h0,        32'hFFFFFFFF, 2'b10, 8'hFD, 7'h7F, 1'b0));
    tbl.push_back(mk(200, 2'b00, 32'h0,        32'hFFFFFFFF, 2'b10, 8'hFD, 7'h7F, 1'b0));
    tbl.push_back(mk(224, 2'b00, 32'h0,        32'hFFFFFFFF, 2'b00, 8'hFF, 7'h7F, 1'b1));
    tbl.push_back(mk(230, 2'b11, 32'h0,        32'hFFFFFFFF, 2'b00, 8'hFF, 7'h7F, 1'b0));
    tbl.push_back(mk(256, 2'b11, 32'h0,        32'hFFFFFFFF, 2'b01, 8'h7F, 7'h7F, 1'b1));
    tbl.push_back(mk(257, 2'b11, 32'h0,        32'hFFFFFFFF, 2'b01, 8'hFE, 7'h40, 1'b0));
    tbl.push_back(mk(289, 2'b11, 32'h0,        32'hFFFFFFFF, 2'b01, 8'hFE, 7'h40, 1'b0));
    tbl.push_back(mk(321, 2'b11, 32'h0,        32'hFFFFFFFF, 2'b10, 8'hFE, 7'h7F, 1'b0));
    tbl.push_back(mk(353, 2'b11, 32'h0,        32'hFFFFFFFF, 2'b10, 8'hFE, 7'h7F, 1'b0));
    tbl.push_back(mk(385, 2'b11, 32'h0,        32'hFFFFFFFF, 2'b01, 8'hFE, 7'h40, 1'b0));
    tbl.push_back(mk(405, 2'b11, 32'h0,        32'hFFFFFFFF, 2'b01, 8'hDF, 7'h40, 1'b0));

    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_an",  32'(AN),  32'hFF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_fd",  32'(frame_done), 32'h0);
    rst_n = 1'b1;
    n = 0;

    foreach (tbl[i]) begin
      req = tbl[i].req; data_a = tbl[i].da; data_b = tbl[i].db;
      step_to(tbl[i].n);
      chk($sformatf("gnt@%0d", tbl[i].n), 32'(gnt), 32'(tbl[i].gnt));
      chk($sformatf("an@%0d",  tbl[i].n), 32'(AN),  32'(tbl[i].an));
      chk($sformatf("seg@%0d", tbl[i].n), 32'(seg), 32'(tbl[i].seg));
      chk($sformatf("fd@%0d",  tbl[i].n), 32'(frame_done), 32'(tbl[i].fd));
    end

    // Asynchronous reset mid-frame at digit 5 while A owns (last owner A).
    rst_n = 1'b0;
    #1;
    chk("async_gnt", 32'(gnt), 32'h0);
    chk("async_an",  32'(AN),  32'hFF);
    chk("async_seg", 32'(seg), 32'h7F);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int k = 1; k <= 32; k++) begin
      step_to(k);
      chk($sformatf("post_rst_fd@%0d", k), 32'(frame_done), (k == 32) ? 32'h1 : 32'h0);
      if (k == 31) chk("post_rst_gnt_pre", 32'(gnt), 32'h0);
    end
    chk("post_rst_a_wins", 32'(gnt), 32'h1);
    step_to(33);
    chk("post_rst_an_d0", 32'(AN), 32'hFE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_arbiter.md
SEG_SCAN_ARBITER -- requirements
Module: seg_scan_arbiter

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 100000: clk cycles per digit slot.
REQ-002 The block SHALL have parameter HOLD_FRAMES, default 16: minimum frames per grant.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port req, input, 2 bits: display request; bit0 = requester A, bit1 = requester B.
REQ-006 The block SHALL have port data_a, input, 32 bits: A's 8 hex nibbles; nibble k (bits 4k+3:4k) drives digit k.
REQ-007 The block SHALL have port data_b, input, 32 bits: B's nibbles, same layout as data_a.
REQ-008 The block SHALL have port gnt, output, 2 bits: one-hot grant, or 00 when idle.
REQ-009 The block SHALL have port AN, output, 8 bits: anode enables, active-low; AN[k] = digit k.
REQ-010 The block SHALL have port seg, output, 7 bits: {CG,CF,CE,CD,CC,CB,CA}, active-low.
REQ-011 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse per completed 8-digit frame.

Function
REQ-012 The block SHALL count 0..SCAN_DIV-1 on a divider; tick = (divider == SCAN_DIV-1); the divider wraps to 0 on the same edge.
REQ-013 On tick, digit index 0..7 SHALL increment, wrapping 7->0.
REQ-014 Frame boundary = tick with digit == 7; frame_done SHALL be registered high for exactly the cycle after the boundary edge.
REQ-015 The block SHALL have state machine states IDLE, OWN_A, OWN_B; gnt = 00/01/10 respectively; the state changes only at frame boundary edges.
REQ-016 The block SHALL keep a last-owner register; on entering OWN_A or OWN_B it becomes that owner.
REQ-017 IDLE at a boundary SHALL transition as follows: only one req set -> own that requester; both set -> own the requester that is not last-owner; none -> stay IDLE.
REQ-018 OWN_X SHALL load hold_cnt = HOLD_FRAMES-1 on entry and decrement it at each boundary while nonzero.
REQ-019 OWN_X at a boundary SHALL transition as follows: req[X]=0 -> own other if req[other], else IDLE; req[X]=1 and hold_cnt==0 and req[other] -> own other; otherwise stay.
REQ-020 Requests pulsed and dropped between boundaries SHALL be ignored; no sticky request latching.
REQ-021 At each boundary edge the 32-bit frame buffer SHALL load the data of the next-state owner, or all-F when the next state is IDLE; the buffer is constant for the whole frame.
REQ-022 The decoder SHALL map nibble to seg as follows: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 B:03 C:46 D:21 E:06 F:7F (blank), all values hex.
REQ-023 AN and seg SHALL be registered from the current digit index and buffer with 1-cycle latency; AN has exactly one zero, at bit digit, when the state is not IDLE.
REQ-024 In IDLE, AN SHALL be FF and seg SHALL be 7F; this also applies in the first cycle after entering IDLE.
REQ-025 gnt SHALL be registered and change on the same edge as the state.

Reset
REQ-026 While rst_n=0 (async), the block SHALL force divider=0, digit=0, state IDLE, last-owner=B, hold_cnt=0, buffer=all-F, gnt=00, AN=FF, seg=7F, frame_done=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately; after release, the first boundary occurs 8*SCAN_DIV cycles later.
REQ-028 After reset, with both requests set at the first boundary, A SHALL win.

Verification (SCAN_DIV=4, HOLD_FRAMES=2; frame = 32 cycles)
REQ-029 Scenario: reset, then hold req=00 -> gnt=00, AN=FF, seg=7F throughout; frame_done pulses every 32 cycles.
REQ-030 Scenario: req=01, data_a=76543210 -> gnt=01 after the first boundary; digits 0..7 show 40,79,24,30,19,12,02,78; each AN low for 4 cycles.
REQ-031 Scenario: req=11 from reset -> A granted for 2 frames, then B for 2 frames, alternating indefinitely.
REQ-032 Scenario: A owns, A drops req mid-frame with req[1]=1 -> at the next boundary gnt=10; data_a changes mid-frame do not alter the displayed frame.
REQ-033 Scenario: rst_n pulsed low at digit 5 -> AN=FF, gnt=00 asynchronously; after release, digit restarts at 0 and the first frame_done occurs 32 cycles later.
REQ-034 Scenario: data_b=FFFFFFFF with B owning -> AN scans while seg=7F on every digit.
